// File: rtl/cond_unit_pkg.sv
// Shared condition codes, flag bit positions and M-stage control bundle for the
// execute-stage condition unit and its condition checker.
package cond_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  typedef struct packed {
    logic pcsrc;
    logic reg_write;
    logic mem_write;
  } m_ctrl_t;

endpackage

// File: rtl/cond_unit_if.sv
// E-stage bundle between the pipeline control and the condition unit.
// Level signals, no handshake: every field is sampled on each rising clock edge.
interface cond_unit_if;
  logic       valid_e;
  logic       stall_e;
  logic       flush_e;
  logic [3:0] cond_e;
  logic [1:0] flag_write_e;
  logic [3:0] alu_flags;
  logic       pcs_e;
  logic       reg_write_e;
  logic       mem_write_e;
  logic       cond_ex_e;
  logic       pcsrc_e;
  logic       reg_write_ge;
  logic       mem_write_ge;
  logic [3:0] flags_q;
  logic       pcsrc_m;
  logic       reg_write_m;
  logic       mem_write_m;

  modport master (
    output valid_e, stall_e, flush_e, cond_e, flag_write_e, alu_flags,
           pcs_e, reg_write_e, mem_write_e,
    input  cond_ex_e, pcsrc_e, reg_write_ge, mem_write_ge, flags_q,
           pcsrc_m, reg_write_m, mem_write_m
  );

  modport slave (
    input  valid_e, stall_e, flush_e, cond_e, flag_write_e, alu_flags,
           pcs_e, reg_write_e, mem_write_e,
    output cond_ex_e, pcsrc_e, reg_write_ge, mem_write_ge, flags_q,
           pcsrc_m, reg_write_m, mem_write_m
  );
endinterface

// File: rtl/cond_unit_cond_check.sv
// Combinational ARM condition-field evaluator against an {N,Z,C,V} flag word.
// Kept standalone so the multi-cycle core can reuse it.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds NZCV, gates PC/register/memory writes on the
// condition result, and registers the gated controls into the Memory stage.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter bit         PIPE_OUT   = 1'b1
) (
  input logic       clk,
  input logic       reset,
  cond_unit_if.slave bus
);
  logic       live_e;
  logic       pass;
  logic       cond_ex;
  logic [3:0] flags_q;
  m_ctrl_t    ctrl_e;
  m_ctrl_t    ctrl_m;

  assign live_e = bus.valid_e & ~bus.flush_e;

  // Evaluated against the stored flags; same-cycle ALU flags only land next cycle.
  cond_check u_cond_check (
    .cond  (bus.cond_e),
    .flags (flags_q),
    .pass  (pass)
  );

  assign cond_ex          = live_e & pass;
  assign ctrl_e.pcsrc     = bus.pcs_e & cond_ex;
  assign ctrl_e.reg_write = bus.reg_write_e & cond_ex;
  assign ctrl_e.mem_write = bus.mem_write_e & cond_ex;

  assign bus.cond_ex_e    = cond_ex;
  assign bus.pcsrc_e      = ctrl_e.pcsrc;
  assign bus.reg_write_ge = ctrl_e.reg_write;
  assign bus.mem_write_ge = ctrl_e.mem_write;
  assign bus.flags_q      = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else if (cond_ex && !bus.stall_e) begin
      if (bus.flag_write_e[FW_NZ]) begin
        flags_q[FLAG_N] <= bus.alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= bus.alu_flags[FLAG_Z];
      end
      if (bus.flag_write_e[FW_CV]) begin
        flags_q[FLAG_C] <= bus.alu_flags[FLAG_C];
        flags_q[FLAG_V] <= bus.alu_flags[FLAG_V];
      end
    end
  end

  generate
    if (PIPE_OUT) begin : g_pipe
      // Flushed or bubble instructions already carry zero controls, so a plain load
      // is enough to inject a bubble into M.
      always_ff @(posedge clk) begin
        if (reset) begin
          ctrl_m <= '0;
        end else if (!bus.stall_e) begin
          ctrl_m <= ctrl_e;
        end
      end
    end else begin : g_nopipe
      assign ctrl_m = '0;
    end
  endgenerate

  assign bus.pcsrc_m     = ctrl_m.pcsrc;
  assign bus.reg_write_m = ctrl_m.reg_write;
  assign bus.mem_write_m = ctrl_m.mem_write;
endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: behavioural NZCV/M-stage model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  cond_unit_if bus ();

  cond_unit #(.FLAG_RESET(4'b0000), .PIPE_OUT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags;
  logic       m_pcsrc_m, m_reg_m, m_mem_m;

  // ARM pairs conditions: odd codes invert the even one below (except 14/15, always).
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c >= 4'd14) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic bit exp_ce();
    return bus.valid_e && !bus.flush_e && cond_ok(bus.cond_e, m_flags);
  endfunction

  always @(posedge clk) begin
    bit ce;
    ce = exp_ce();
    if (reset) begin
      m_flags = 4'b0000;
      m_pcsrc_m = 0; m_reg_m = 0; m_mem_m = 0;
    end else if (!bus.stall_e) begin
      if (ce && bus.flag_write_e[1]) m_flags[3:2] = bus.alu_flags[3:2];
      if (ce && bus.flag_write_e[0]) m_flags[1:0] = bus.alu_flags[1:0];
      m_pcsrc_m = bus.pcs_e && ce;
      m_reg_m   = bus.reg_write_e && ce;
      m_mem_m   = bus.mem_write_e && ce;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ce;
      ce = exp_ce();
      chk("cond_ex_e",    {3'b0, bus.cond_ex_e},    {3'b0, ce});
      chk("pcsrc_e",      {3'b0, bus.pcsrc_e},      {3'b0, ce && bus.pcs_e});
      chk("reg_write_ge", {3'b0, bus.reg_write_ge}, {3'b0, ce && bus.reg_write_e});
      chk("mem_write_ge", {3'b0, bus.mem_write_ge}, {3'b0, ce && bus.mem_write_e});
      chk("flags_q",      bus.flags_q,              m_flags);
      chk("pcsrc_m",      {3'b0, bus.pcsrc_m},      {3'b0, m_pcsrc_m});
      chk("reg_write_m",  {3'b0, bus.reg_write_m},  {3'b0, m_reg_m});
      chk("mem_write_m",  {3'b0, bus.mem_write_m},  {3'b0, m_mem_m});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit st, input bit fl, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input bit p, input bit rw, input bit mw);
    @(posedge clk); #1;
    bus.valid_e = v; bus.stall_e = st; bus.flush_e = fl; bus.cond_e = c;
    bus.flag_write_e = fw; bus.alu_flags = alu;
    bus.pcs_e = p; bus.reg_write_e = rw; bus.mem_write_e = mw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1, 0, 0, 4'hE, 2'b11, f, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.valid_e = 0; bus.stall_e = 1; bus.flush_e = 0; bus.cond_e = 4'h0;
    bus.flag_write_e = 2'b00; bus.alu_flags = 4'h0;
    bus.pcs_e = 0; bus.reg_write_e = 0; bus.mem_write_e = 0;

    // 1: reset with stall held
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; bus.stall_e = 0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_flags", bus.flags_q, 4'b0000);
    chk("rst_m", {1'b0, bus.pcsrc_m, bus.reg_write_m, bus.mem_write_m}, 4'b0000);

    // 2: split flag write
    drive(1, 0, 0, 4'hE, 2'b10, 4'b1111, 0, 0, 0);
    drive(1, 0, 0, 4'hE, 2'b01, 4'b0011, 0, 0, 0);
    @(negedge clk);
    chk("split_nz", bus.flags_q, 4'b1100);
    idle();
    @(negedge clk);
    chk("split_cv", bus.flags_q, 4'b1111);

    // 3: every cond against every flag value
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        set_flags(4'(f));
        drive(1, 0, 0, 4'(c), 2'b00, 4'h0, 0, 1, 0);
      end
    end
    set_flags(4'b0110);
    drive(1, 0, 0, 4'h8, 2'b00, 4'h0, 0, 1, 0);
    @(negedge clk);
    chk("hi_c_z", {3'b0, bus.reg_write_ge}, 4'b0000);
    drive(1, 0, 0, 4'h9, 2'b00, 4'h0, 0, 1, 0);
    @(negedge clk);
    chk("ls_c_z", {3'b0, bus.reg_write_ge}, 4'b0001);

    // 4: CMP sets Z, BEQ next cycle
    set_flags(4'b0000);
    drive(1, 0, 0, 4'hE, 2'b11, 4'b0100, 0, 0, 0);
    drive(1, 0, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0);
    @(negedge clk);
    chk("beq_pcsrc_e", {3'b0, bus.pcsrc_e}, 4'b0001);
    idle();
    @(negedge clk);
    chk("beq_pcsrc_m", {3'b0, bus.pcsrc_m}, 4'b0001);

    // 5: failed condition blocks flags and store
    set_flags(4'b0000);
    drive(1, 0, 0, 4'h0, 2'b11, 4'b1010, 0, 0, 1);
    @(negedge clk);
    chk("fail_mem_ge", {3'b0, bus.mem_write_ge}, 4'b0000);
    idle();
    @(negedge clk);
    chk("fail_flags", bus.flags_q, 4'b0000);
    chk("fail_mem_m", {3'b0, bus.mem_write_m}, 4'b0000);

    // 6: stall and flush
    drive(1, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 1);
    drive(1, 1, 0, 4'hE, 2'b11, 4'b1111, 0, 0, 0);
    drive(1, 1, 0, 4'hE, 2'b11, 4'b1111, 0, 0, 0);
    @(negedge clk);
    chk("stall_mem_m", {3'b0, bus.mem_write_m}, 4'b0001);
    chk("stall_flags", bus.flags_q, 4'b0000);
    drive(1, 1, 1, 4'hE, 2'b11, 4'b1111, 0, 0, 1);
    @(negedge clk);
    chk("stfl_mem_m", {3'b0, bus.mem_write_m}, 4'b0001);
    drive(1, 0, 1, 4'hE, 2'b11, 4'b1111, 0, 0, 1);
    @(negedge clk);
    chk("flush_mem_m", {3'b0, bus.mem_write_m}, 4'b0001);
    idle();
    @(negedge clk);
    chk("flush_bubble", {3'b0, bus.mem_write_m}, 4'b0000);
    chk("flush_flags", bus.flags_q, 4'b0000);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
